// File: rtl/dco_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dco_pkg
// Description : Shared constants and helpers for the dco_array oscillator bank.
// Revision    : 1.0 - initial release
// ============================================================================
package dco_pkg;

    localparam bit DCO_BINARY = 1'b0;
    localparam bit DCO_ONEHOT = 1'b1;

    // Counter reload value: half-period minus one, with code 0 mapping to 0
    // so an idle code reloads a zero counter.
    function automatic logic [31:0] half_period(input logic [31:0] code, input bit mode);
        logic [31:0] r;
        r = '0;
        if (code != '0) begin
            if (mode == DCO_BINARY) begin
                r = code - 32'd1;
            end else begin
                for (int k = 0; k < 32; k++) begin
                    if (code[k]) r = (32'd1 << k) - 32'd1;
                end
            end
        end
        return r;
    endfunction

    function automatic int sel_width(input int nch);
        return (nch <= 1) ? 1 : $clog2(nch);
    endfunction

endpackage : dco_pkg
`default_nettype wire

// File: rtl/dco_if.sv
`default_nettype none
// ============================================================================
// Module      : dco_if
// Description : Code-write and oscillator-output bundle for dco_array.
// Revision    : 1.0 - initial release
// ============================================================================
interface dco_if
    import dco_pkg::*;
#(
    parameter int CODE_W = 8,
    parameter int NCH    = 2
) ();

    localparam int c_SEL_W = sel_width(NCH);

    logic                ena;
    logic [CODE_W-1:0]   code_in;
    logic [c_SEL_W-1:0]  ch_sel;
    logic                code_wr;
    logic [NCH-1:0]      dco_out;
    logic [NCH-1:0]      tick;
    logic [NCH-1:0]      pending;

    modport master (
        output ena, code_in, ch_sel, code_wr,
        input  dco_out, tick, pending
    );

    modport slave (
        input  ena, code_in, ch_sel, code_wr,
        output dco_out, tick, pending
    );

endinterface : dco_if
`default_nettype wire

// File: rtl/dco_channel.sv
`default_nettype none
// ============================================================================
// Module      : dco_channel
// Description : One oscillator: active/shadow code, down-counter, output level.
// Revision    : 1.0 - initial release
// ============================================================================
module dco_channel
    import dco_pkg::*;
#(
    parameter int CODE_W = 8,
    parameter bit MODE   = DCO_BINARY
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    input  wire logic              ena,
    input  wire logic              wr,
    input  wire logic [CODE_W-1:0] code,
    output logic                   out,
    output logic                   tick,
    output logic                   pending
);

    logic [CODE_W-1:0] r_active;
    logic [CODE_W-1:0] r_shadow;
    logic              r_pend;
    logic [CODE_W-1:0] r_cnt;
    logic              r_out;
    logic              r_tick;

    logic [CODE_W-1:0] w_next;
    logic [CODE_W-1:0] w_hp;

    always_comb begin
        w_next = r_pend ? r_shadow : r_active;
        w_hp   = CODE_W'(half_period(32'(w_next), MODE));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_active <= '0;
            r_shadow <= '0;
            r_pend   <= 1'b0;
            r_cnt    <= '0;
            r_out    <= 1'b0;
            r_tick   <= 1'b0;
        end else begin
            r_tick <= 1'b0;
            if (ena) begin
                if (r_active == '0) begin
                    // Idle: adopt any pending code, output stays low.
                    r_out    <= 1'b0;
                    r_active <= w_next;
                    r_cnt    <= w_hp;
                    r_pend   <= 1'b0;
                end else if (r_cnt != '0) begin
                    r_cnt <= r_cnt - CODE_W'(1);
                end else begin
                    r_active <= w_next;
                    r_pend   <= 1'b0;
                    if (w_next != '0) begin
                        r_out  <= ~r_out;
                        r_tick <= 1'b1;
                        r_cnt  <= w_hp;
                    end else begin
                        r_out  <= 1'b0;
                        r_cnt  <= '0;
                        r_tick <= r_out;
                    end
                end
            end
            // Placed last so a write on a boundary edge stays pending for the next one.
            if (wr) begin
                r_shadow <= code;
                r_pend   <= 1'b1;
            end
        end
    end

    assign out     = r_out;
    assign tick    = r_tick;
    assign pending = r_pend;

endmodule : dco_channel
`default_nettype wire

// File: rtl/dco_array.sv
`default_nettype none
// ============================================================================
// Module      : dco_array
// Description : NCH glitch-free digitally controlled oscillators with shadowed codes.
// Revision    : 1.0 - initial release
// ============================================================================
module dco_array
    import dco_pkg::*;
#(
    parameter int CODE_W = 8,
    parameter int NCH    = 2,
    parameter int ONEHOT = 0
) (
    input  wire logic clk,
    input  wire logic rst_n,
    dco_if.slave      bus
);

    localparam int c_SEL_W = sel_width(NCH);
    localparam bit c_MODE  = (ONEHOT != 0) ? DCO_ONEHOT : DCO_BINARY;

    logic [NCH-1:0] w_wr;
    logic [NCH-1:0] w_out;
    logic [NCH-1:0] w_tick;
    logic [NCH-1:0] w_pend;

    generate
        for (genvar i = 0; i < NCH; i++) begin : g_ch
            // Selects outside 0..NCH-1 match no channel and are dropped.
            assign w_wr[i] = bus.code_wr && (bus.ch_sel == c_SEL_W'(i));

            dco_channel #(
                .CODE_W (CODE_W),
                .MODE   (c_MODE)
            ) u_ch (
                .clk     (clk),
                .rst_n   (rst_n),
                .ena     (bus.ena),
                .wr      (w_wr[i]),
                .code    (bus.code_in),
                .out     (w_out[i]),
                .tick    (w_tick[i]),
                .pending (w_pend[i])
            );
        end
    endgenerate

    assign bus.dco_out = w_out;
    assign bus.tick    = w_tick;
    assign bus.pending = w_pend;

endmodule : dco_array
`default_nettype wire

// File: tb/tb_dco_array.sv
`default_nettype none
// ============================================================================
// Module      : tb_dco_array
// Description : Directed self-checking bench for dco_array (binary and one-hot).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dco_array;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_fail;

    dco_if #(.CODE_W(8), .NCH(2)) bif ();
    dco_if #(.CODE_W(8), .NCH(2)) oif ();

    dco_array #(.CODE_W(8), .NCH(2), .ONEHOT(0)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bif));
    dco_array #(.CODE_W(8), .NCH(2), .ONEHOT(1)) dut_o (.clk(clk), .rst_n(rst_n), .bus(oif));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr_b(input int ch, input logic [7:0] c);
        bif.ch_sel  = ch[0];
        bif.code_in = c;
        bif.code_wr = 1'b1;
        step(1);
        bif.code_wr = 1'b0;
    endtask

    task automatic wr_o(input int ch, input logic [7:0] c);
        oif.ch_sel  = ch[0];
        oif.code_in = c;
        oif.code_wr = 1'b1;
        step(1);
        oif.code_wr = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            bif.ch_sel = k[0]; bif.code_in = 8'd3; bif.code_wr = 1'b1;
            step(1);
            n_chk++; if ({bif.dco_out, bif.tick, bif.pending} !== 6'b0) begin n_fail++; $display("FAIL reset_hold: out/tick/pend=%b expected=%b", {bif.dco_out, bif.tick, bif.pending}, 6'b0); end
        end
        bif.code_wr = 1'b0;
        rst_n = 1'b1;
        for (int k = 0; k < 50; k++) begin
            step(1);
            n_chk++; if ({bif.dco_out, bif.pending, oif.dco_out} !== 6'b0) begin n_fail++; $display("FAIL reset_idle cycle %0d: got=%b expected=%b", k, {bif.dco_out, bif.pending, oif.dco_out}, 6'b0); end
        end
    endtask

    task automatic test_binary();
        logic exp_o, exp_t;
        do_reset();
        wr_b(0, 8'd3);
        n_chk++; if (bif.pending !== 2'b01) begin n_fail++; $display("FAIL bin_pend_rise: pending=%b expected=%b", bif.pending, 2'b01); end
        step(1);
        n_chk++; if (bif.pending !== 2'b00) begin n_fail++; $display("FAIL bin_pend_fall: pending=%b expected=%b", bif.pending, 2'b00); end
        step(2);
        n_chk++; if (bif.dco_out !== 2'b00) begin n_fail++; $display("FAIL bin_before_rise: dco_out=%b expected=%b", bif.dco_out, 2'b00); end
        for (int k = 0; k < 12; k++) begin
            step(1);
            exp_o = ((k / 3) % 2) == 0;
            exp_t = (k % 3) == 0;
            n_chk++; if (bif.dco_out !== {1'b0, exp_o} || bif.tick !== {1'b0, exp_t}) begin n_fail++; $display("FAIL bin_wave k=%0d: out=%b tick=%b expected out=%b tick=%b", k, bif.dco_out, bif.tick, {1'b0, exp_o}, {1'b0, exp_t}); end
        end
    endtask

    task automatic test_onehot();
        do_reset();
        wr_o(0, 8'b0000_0100);
        step(4);
        n_chk++; if (oif.dco_out[0] !== 1'b0) begin n_fail++; $display("FAIL oh_pre_rise: out=%b expected=0", oif.dco_out[0]); end
        step(1);
        n_chk++; if (oif.dco_out[0] !== 1'b1 || oif.tick[0] !== 1'b1) begin n_fail++; $display("FAIL oh_rise: out=%b tick=%b expected 1 1", oif.dco_out[0], oif.tick[0]); end
        step(3);
        n_chk++; if (oif.dco_out[0] !== 1'b1) begin n_fail++; $display("FAIL oh_high: out=%b expected=1", oif.dco_out[0]); end
        step(1);
        n_chk++; if (oif.dco_out[0] !== 1'b0) begin n_fail++; $display("FAIL oh_fall: out=%b expected=0", oif.dco_out[0]); end
        step(4);
        n_chk++; if (oif.dco_out[0] !== 1'b1) begin n_fail++; $display("FAIL oh_rise2: out=%b expected=1", oif.dco_out[0]); end
        wr_o(0, 8'b1000_0000);
        step(2);
        n_chk++; if (oif.dco_out[0] !== 1'b1 || oif.pending[0] !== 1'b1) begin n_fail++; $display("FAIL oh_hold4: out=%b pend=%b expected 1 1", oif.dco_out[0], oif.pending[0]); end
        step(1);
        n_chk++; if (oif.dco_out[0] !== 1'b0 || oif.pending[0] !== 1'b0) begin n_fail++; $display("FAIL oh_apply128: out=%b pend=%b expected 0 0", oif.dco_out[0], oif.pending[0]); end
        step(127);
        n_chk++; if (oif.dco_out[0] !== 1'b0) begin n_fail++; $display("FAIL oh_low128: out=%b expected=0", oif.dco_out[0]); end
        step(1);
        n_chk++; if (oif.dco_out[0] !== 1'b1) begin n_fail++; $display("FAIL oh_rise128: out=%b expected=1", oif.dco_out[0]); end
        wr_o(0, 8'b0110_0000);
        step(126);
        n_chk++; if (oif.dco_out[0] !== 1'b1) begin n_fail++; $display("FAIL oh_high128: out=%b expected=1", oif.dco_out[0]); end
        step(1);
        n_chk++; if (oif.dco_out[0] !== 1'b0) begin n_fail++; $display("FAIL oh_fall128: out=%b expected=0", oif.dco_out[0]); end
        step(63);
        n_chk++; if (oif.dco_out[0] !== 1'b0) begin n_fail++; $display("FAIL oh_low64: out=%b expected=0", oif.dco_out[0]); end
        step(1);
        n_chk++; if (oif.dco_out !== 2'b01) begin n_fail++; $display("FAIL oh_rise64: out=%b expected=%b", oif.dco_out, 2'b01); end
    endtask

    task automatic test_glitch_free();
        do_reset();
        wr_b(0, 8'd10);
        step(10);
        n_chk++; if (bif.dco_out[0] !== 1'b0) begin n_fail++; $display("FAIL gf_pre_rise: out=%b expected=0", bif.dco_out[0]); end
        step(1);
        n_chk++; if (bif.dco_out[0] !== 1'b1 || bif.tick[0] !== 1'b1) begin n_fail++; $display("FAIL gf_rise: out=%b tick=%b expected 1 1", bif.dco_out[0], bif.tick[0]); end
        step(2);
        wr_b(0, 8'd2);
        wr_b(0, 8'd5);
        n_chk++; if (bif.pending[0] !== 1'b1) begin n_fail++; $display("FAIL gf_pend: pending=%b expected=1", bif.pending[0]); end
        step(5);
        n_chk++; if (bif.dco_out[0] !== 1'b1 || bif.pending[0] !== 1'b1) begin n_fail++; $display("FAIL gf_full_half: out=%b pend=%b expected 1 1", bif.dco_out[0], bif.pending[0]); end
        step(1);
        n_chk++; if (bif.dco_out[0] !== 1'b0 || bif.tick[0] !== 1'b1 || bif.pending[0] !== 1'b0) begin n_fail++; $display("FAIL gf_boundary: out=%b tick=%b pend=%b expected 0 1 0", bif.dco_out[0], bif.tick[0], bif.pending[0]); end
        step(4);
        n_chk++; if (bif.dco_out[0] !== 1'b0) begin n_fail++; $display("FAIL gf_low5: out=%b expected=0", bif.dco_out[0]); end
        step(1);
        n_chk++; if (bif.dco_out[0] !== 1'b1) begin n_fail++; $display("FAIL gf_rise5: out=%b expected=1", bif.dco_out[0]); end
        step(5);
        n_chk++; if (bif.dco_out[0] !== 1'b0) begin n_fail++; $display("FAIL gf_fall5: out=%b expected=0", bif.dco_out[0]); end
    endtask

    task automatic test_enable();
        do_reset();
        wr_b(0, 8'd6);
        step(9);
        n_chk++; if (bif.dco_out[0] !== 1'b1) begin n_fail++; $display("FAIL en_pre: out=%b expected=1", bif.dco_out[0]); end
        bif.ena = 1'b0;
        for (int k = 0; k < 7; k++) begin
            step(1);
            n_chk++; if (bif.dco_out[0] !== 1'b1 || bif.tick !== 2'b00) begin n_fail++; $display("FAIL en_freeze k=%0d: out=%b tick=%b expected 1 00", k, bif.dco_out[0], bif.tick); end
        end
        bif.ena = 1'b1;
        wr_b(0, 8'd0);
        step(2);
        n_chk++; if (bif.dco_out[0] !== 1'b1 || bif.pending[0] !== 1'b1) begin n_fail++; $display("FAIL en_resume: out=%b pend=%b expected 1 1", bif.dco_out[0], bif.pending[0]); end
        step(1);
        n_chk++; if (bif.dco_out[0] !== 1'b0 || bif.tick[0] !== 1'b1 || bif.pending[0] !== 1'b0) begin n_fail++; $display("FAIL en_stop: out=%b tick=%b pend=%b expected 0 1 0", bif.dco_out[0], bif.tick[0], bif.pending[0]); end
        for (int k = 0; k < 20; k++) begin
            step(1);
            n_chk++; if (bif.dco_out !== 2'b00 || bif.tick !== 2'b00) begin n_fail++; $display("FAIL en_idle k=%0d: out=%b tick=%b expected 00 00", k, bif.dco_out, bif.tick); end
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int j = 0; j < 8; j++) wr_b(j % 2, 8'(2 + j));
        n_chk++; if (bif.pending[1] !== 1'b1) begin n_fail++; $display("FAIL b2b_pend: pending[1]=%b expected=1", bif.pending[1]); end
        step(7);
        rst_n = 1'b0;
        wr_b(0, 8'd9);
        rst_n = 1'b1;
        n_chk++; if ({bif.dco_out, bif.tick, bif.pending} !== 6'b0) begin n_fail++; $display("FAIL b2b_reset: out/tick/pend=%b expected=%b", {bif.dco_out, bif.tick, bif.pending}, 6'b0); end
        for (int k = 0; k < 40; k++) begin
            step(1);
            n_chk++; if ({bif.dco_out, bif.pending} !== 4'b0) begin n_fail++; $display("FAIL b2b_idle k=%0d: out/pend=%b expected=%b", k, {bif.dco_out, bif.pending}, 4'b0); end
        end
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        bif.ena = 1'b1; bif.code_in = '0; bif.ch_sel = '0; bif.code_wr = 1'b0;
        oif.ena = 1'b1; oif.code_in = '0; oif.ch_sel = '0; oif.code_wr = 1'b0;
        test_reset();
        test_binary();
        test_onehot();
        test_glitch_free();
        test_enable();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule : tb_dco_array
`default_nettype wire
